lsu_port_arbiter: RTL and testbench

//  Shares the single LSU data port (load/store unit: RAM plus memory-mapped LCD/LED/HEX/SW I/O) between two requesters.
//  - Port 0 (m0): pipeline MEM stage.
//  - Port 1 (m1): DMA/debug master.

---
 rtl/lsu_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_port_arbiter
//   Shares the single LSU data port between the pipeline MEM stage (m0) and
//   a DMA/debug master (m1). m0 has fixed priority. A starvation guard forces
//   m1 ahead after STARVE_MAX consecutive denied cycles. m1 may hold the port
//   for a locked burst of up to LOCK_MAX beats. After a forced release there
//   is one m0-only backoff cycle. Load data returns one cycle after the grant
//   and is routed to the port that issued the load.
//
//   Optional feature macro: LSU_ARB_PERF_EN
//     defined   : o_stall_cnt / o_m1_beats are 32-bit wrapping perf counters
//     undefined : both tied to 0, no counter flops
//
// Ports
//   i_clk, i_rst_n          clock (rising), async active-low reset
//   i_m0_*                  MEM-stage request: req, wren, addr, wdata
//   o_m0_gnt, o_stall_m     m0 grant, MEM-stage stall (req & ~gnt)
//   o_m0_rvalid/o_m0_rdata  m0 load return
//   i_m1_*                  m1 request: req, wren, lock, addr, wdata
//   o_m1_gnt                m1 grant
//   o_m1_rvalid/o_m1_rdata  m1 load return
//   o_lsu_addr/wdata/wren   to LSU (granted port, or 0 when idle)
//   i_lsu_rdata             LSU load data, valid the cycle after a load grant
//   o_stall_cnt, o_m1_beats perf counters
// ---------------------------------------------------------------------------
module lsu_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_wren,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_stall_m,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wren,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_wdata,
  output logic              o_lsu_wren,
  input  logic [DATA_W-1:0] i_lsu_rdata,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_m1_beats
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_LIM   = LW'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK1   = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_starve;
  logic [LW-1:0]   r_lock_cnt;
  logic            r_rd_pend;
  logic            r_rd_owner;   // 1 = m1 owns the pending load

  logic            w_m0_gnt;
  logic            w_m1_gnt;
  logic [LW-1:0]   w_lock_inc;

  // Grants. Gated by reset so every grant (and thus the LSU write strobe)
  // drops the moment reset asserts, not at the next edge.
  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE: begin
          w_m0_gnt = i_m0_req & (r_starve < STARVE_LIM);
          w_m1_gnt = i_m1_req & ~(i_m0_req & (r_starve < STARVE_LIM));
        end
        ST_LOCK1:   w_m1_gnt = i_m1_req;
        ST_BACKOFF: w_m0_gnt = i_m0_req;
        default: begin
          w_m0_gnt = 1'b0;
          w_m1_gnt = 1'b0;
        end
      endcase
    end
  end

  assign o_m0_gnt  = w_m0_gnt;
  assign o_m1_gnt  = w_m1_gnt;
  assign o_stall_m = i_m0_req & ~w_m0_gnt;

  // LSU request mux: granted port, or all-zero when nobody is granted.
  always_comb begin
    o_lsu_addr  = '0;
    o_lsu_wdata = '0;
    o_lsu_wren  = 1'b0;
    if (w_m0_gnt) begin
      o_lsu_addr  = i_m0_addr;
      o_lsu_wdata = i_m0_wdata;
      o_lsu_wren  = i_m0_wren;
    end else if (w_m1_gnt) begin
      o_lsu_addr  = i_m1_addr;
      o_lsu_wdata = i_m1_wdata;
      o_lsu_wren  = i_m1_wren;
    end
  end

  // Starvation counter: counts consecutive cycles m1 waits; any cycle m1 is
  // granted or not asking clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (i_m1_req & ~w_m1_gnt) begin
      if (r_starve != STARVE_LIM) r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  assign w_lock_inc = r_lock_cnt + 1'b1;

  // Lock FSM. A burst starts with an IDLE m1 grant carrying lock; each
  // further granted beat counts. Dropping lock ends the burst cleanly;
  // reaching LOCK_MAX forces one BACKOFF cycle so m0 gets a turn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_m1_gnt & i_m1_lock) begin
            r_state    <= ST_LOCK1;
            r_lock_cnt <= LW'(1);
          end
        end
        ST_LOCK1: begin
          if (!i_m1_req) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end else if (!i_m1_lock) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end else if (w_lock_inc == LOCK_LIM) begin
            r_state    <= ST_BACKOFF;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= w_lock_inc;
          end
        end
        ST_BACKOFF: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  // Read-return tracking. One outstanding load at most (latency 1), so a
  // single pending bit plus owner is enough; a new grant can issue while the
  // previous load data is being returned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= (w_m0_gnt & ~i_m0_wren) | (w_m1_gnt & ~i_m1_wren);
      r_rd_owner <= w_m1_gnt;
    end
  end

  assign o_m0_rvalid = r_rd_pend & ~r_rd_owner;
  assign o_m1_rvalid = r_rd_pend &  r_rd_owner;
  assign o_m0_rdata  = o_m0_rvalid ? i_lsu_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_lsu_rdata : '0;

`ifdef LSU_ARB_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_m1_beats;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_m1_beats  <= '0;
    end else begin
      if (o_stall_m) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_m1_gnt)  r_m1_beats  <= r_m1_beats + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_m1_beats  = r_m1_beats;
`else
  assign o_stall_cnt = 32'h0;
  assign o_m1_beats  = 32'h0;
`endif

endmodule

// File: tb/tb_lsu_port_arbiter.sv
module tb_lsu_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;
  localparam int LMAX = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_m0_req, i_m0_wren;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_wdata;
  logic          o_m0_gnt, o_stall_m, o_m0_rvalid;
  logic [DW-1:0] o_m0_rdata;
  logic          i_m1_req, i_m1_wren, i_m1_lock;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_wdata;
  logic          o_m1_gnt, o_m1_rvalid;
  logic [DW-1:0] o_m1_rdata;
  logic [AW-1:0] o_lsu_addr;
  logic [DW-1:0] o_lsu_wdata;
  logic          o_lsu_wren;
  logic [DW-1:0] i_lsu_rdata;
  logic [31:0]   o_stall_cnt, o_m1_beats;

  lsu_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_stall_m(o_stall_m), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_lock(i_m1_lock), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_lsu_addr(o_lsu_addr), .o_lsu_wdata(o_lsu_wdata), .o_lsu_wren(o_lsu_wren),
    .i_lsu_rdata(i_lsu_rdata), .o_stall_cnt(o_stall_cnt), .o_m1_beats(o_m1_beats)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: arbitration described in terms of "how long has m1
  // waited", "how many beats of the current burst are done" and "is this the
  // mandatory m0 turn after a maxed-out burst".
  int          m_wait;        // consecutive denied m1 cycles, capped at SMAX
  int          m_burst;       // beats done in current locked burst, 0 = none
  bit          m_m0_turn;     // one-cycle m0-only turn after a full burst
  bit          m_pend, m_own; // outstanding load and its owner (1 = m1)
  logic [31:0] m_stalls, m_beats;
  bit          eg0, eg1;

  typedef struct {
    bit m0r, m0w, m1r, m1w, m1l;
    bit g0, g1, st;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_burst = 0; m_m0_turn = 0; m_pend = 0; m_own = 0;
    m_stalls = 0; m_beats = 0;
  endtask

  function automatic void model_grant();
    if (m_m0_turn) begin
      eg0 = i_m0_req; eg1 = 1'b0;
    end else if (m_burst > 0) begin
      eg0 = 1'b0; eg1 = i_m1_req;
    end else begin
      eg0 = i_m0_req && (m_wait < SMAX);
      eg1 = i_m1_req && !eg0;
    end
  endfunction

  // Compare every DUT output against the model for the current inputs.
  task automatic settle_check();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ew;
    #1;
    model_grant();
    ea = eg0 ? i_m0_addr : eg1 ? i_m1_addr : '0;
    ed = eg0 ? i_m0_wdata : eg1 ? i_m1_wdata : '0;
    ew = eg0 ? i_m0_wren : eg1 ? i_m1_wren : 1'b0;
    chk("ctl{g0,g1,stall,wren,rv0,rv1}",
        {o_m0_gnt, o_m1_gnt, o_stall_m, o_lsu_wren, o_m0_rvalid, o_m1_rvalid},
        {eg0, eg1, i_m0_req & !eg0, ew, m_pend & !m_own, m_pend & m_own});
    chk("lsu_addr", o_lsu_addr, ea);
    chk("lsu_wdata", o_lsu_wdata, ed);
    chk("m0_rdata", o_m0_rdata, (m_pend && !m_own) ? i_lsu_rdata : '0);
    chk("m1_rdata", o_m1_rdata, (m_pend && m_own) ? i_lsu_rdata : '0);
`ifdef LSU_ARB_PERF_EN
    chk("perf", {o_stall_cnt, o_m1_beats}, {m_stalls, m_beats});
`else
    chk("perf_off", {o_stall_cnt, o_m1_beats}, 64'h0);
`endif
  endtask

  task automatic advance();
    @(posedge i_clk);
    if (i_m0_req && !eg0) m_stalls++;
    if (eg1) m_beats++;
    m_pend = (eg0 && !i_m0_wren) || (eg1 && !i_m1_wren);
    m_own  = eg1;
    if (m_m0_turn) m_m0_turn = 0;
    else if (m_burst > 0) begin
      if (!i_m1_req || !i_m1_lock) m_burst = 0;
      else if (m_burst + 1 == LMAX) begin m_burst = 0; m_m0_turn = 1; end
      else m_burst++;
    end else if (eg1 && i_m1_lock) m_burst = 1;
    m_wait = (i_m1_req && !eg1) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_m0_req = 0; i_m0_wren = 0; i_m0_addr = '0; i_m0_wdata = '0;
    i_m1_req = 0; i_m1_wren = 0; i_m1_lock = 0; i_m1_addr = '0; i_m1_wdata = '0;
    i_lsu_rdata = $urandom;
  endtask

  task automatic add(input bit m0r, m0w, m1r, m1w, m1l, g0, g1, st);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.m1l = m1l;
    v.g0 = g0; v.g1 = g1; v.st = st;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("reset_outs", {o_m0_gnt, o_m1_gnt, o_stall_m, o_lsu_wren, o_m0_rvalid, o_m1_rvalid,
        o_lsu_addr, o_stall_cnt}, 0);
    i_rst_n = 1;
  endtask

  initial begin
    bit hold;
    i_rst_n = 0;
    idle_inputs();
    @(negedge i_clk);
    do_reset();

    // m0 load alone; starvation pattern; 3-beat lock; 10-beat lock vs LOCK_MAX.
    add(1,0,0,0,0, 1,0,0);
    add(0,0,0,0,0, 0,0,0);
    for (int k = 0; k < 4; k++) add(1,0,1,0,0, 1,0,0);
    add(1,0,1,0,0, 0,1,1);
    for (int k = 0; k < 4; k++) add(1,1,1,1,1, 1,0,0);
    add(1,1,1,1,1, 0,1,1);
    add(1,1,1,1,1, 0,1,1);
    add(1,1,1,1,0, 0,1,1);
    add(1,0,0,0,0, 1,0,0);
    for (int k = 0; k < 8; k++) add(0,0,1,0,1, 0,1,0);
    add(1,0,1,0,1, 1,0,0);
    add(0,0,1,0,1, 0,1,0);
    add(0,0,1,0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0);

    foreach (tv[i]) begin
      i_m0_req = tv[i].m0r; i_m0_wren = tv[i].m0w;
      i_m0_addr = 32'h10 + 32'(i) * 4; i_m0_wdata = $urandom;
      i_m1_req = tv[i].m1r; i_m1_wren = tv[i].m1w; i_m1_lock = tv[i].m1l;
      i_m1_addr = 32'h2000 + 32'(i); i_m1_wdata = $urandom;
      i_lsu_rdata = (i == 1) ? 32'hDEADBEEF : $urandom;
      #1;
      chk($sformatf("vec%0d{g0,g1,stall}", i), {o_m0_gnt, o_m1_gnt, o_stall_m},
          {tv[i].g0, tv[i].g1, tv[i].st});
      if (i == 0) chk("m0_addr_0x10", o_lsu_addr, 32'h10);
      if (i == 1) chk("m0_ld_return", {o_m0_rvalid, o_m0_rdata}, {1'b1, 32'hDEADBEEF});
      settle_check();
      advance();
    end

    // Async reset the cycle after a locked m1 load grant.
    idle_inputs();
    i_m1_req = 1; i_m1_lock = 1; i_m1_addr = 32'h3000;
    settle_check();
    chk("rst_seq_m1_gnt", o_m1_gnt, 1'b1);
    advance();
    #1;
    i_rst_n = 0;
    #1;
    chk("rst_async_outs", {o_m0_gnt, o_m1_gnt, o_m1_rvalid, o_m0_rvalid, o_lsu_wren,
        o_lsu_addr, o_m1_rdata}, 0);
    model_reset();
    @(negedge i_clk);
    chk("rst_hold_outs", {o_m1_gnt, o_m1_rvalid, o_lsu_addr, o_stall_cnt, o_m1_beats}, 0);
    i_rst_n = 1;
    i_m0_req = 1; i_m0_addr = 32'h44;
    settle_check();
    chk("rst_then_idle_m0_wins", {o_m0_gnt, o_m1_gnt, o_m1_rvalid}, 3'b100);
    advance();

    // Randomized traffic; m1 holds its request until granted.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      i_m0_req = ($urandom_range(0, 9) < 7);
      i_m0_wren = $urandom; i_m0_addr = $urandom; i_m0_wdata = $urandom;
      if (!hold) begin
        i_m1_req = ($urandom_range(0, 9) < 5);
        i_m1_wren = $urandom; i_m1_addr = $urandom; i_m1_wdata = $urandom;
      end
      i_m1_lock = ($urandom_range(0, 9) < 8);
      i_lsu_rdata = $urandom;
      settle_check();
      hold = i_m1_req && !eg1;
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
